ddr3_cmd_queue: RTL

DDR3_CMD_QUEUE -- requirements
Module: ddr3_cmd_queue

---
 rtl/ddr3_cmd_queue.sv | 67 ++++++
 1 files changed

// File: rtl/ddr3_cmd_queue.sv
// ddr3_cmd_queue: registered FIFO of DDR3 commands between CPU and controller core.
// Defining DDR3_CMDQ_STATS_EN adds RD_CNT/WR_CNT accepted-push counters.
module ddr3_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          CPU_CLK,
  input  logic          RESET_N,
  input  logic          ADDR_VALID,
  input  logic          CMD,
  input  logic [2:0]    BA,
  input  logic [14:0]   ADDR,
  input  logic [63:0]   WR_DATA,
  input  logic [7:0]    DM,
  output logic          CMD_RDY,
  output logic          Q_VALID,
  output logic          Q_CMD,
  output logic [2:0]    Q_BA,
  output logic [14:0]   Q_ADDR,
  output logic [63:0]   Q_WR_DATA,
  output logic [7:0]    Q_DM,
  input  logic          Q_POP,
  output logic [LW-1:0] Q_LEVEL
`ifdef DDR3_CMDQ_STATS_EN
  ,
  output logic [15:0]   RD_CNT,
  output logic [15:0]   WR_CNT
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 91;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level_n;
  logic push, pop;
  assign push = ADDR_VALID && CMD_RDY;
  assign pop = Q_POP && Q_VALID;
  assign level_n = Q_LEVEL + LW'(push) - LW'(pop);
  // Head fields come straight from storage; blanked whenever the queue reports empty.
  assign {Q_CMD, Q_BA, Q_ADDR, Q_WR_DATA, Q_DM} = Q_VALID ? mem[rd_ptr] : '0;
  always_ff @(posedge CPU_CLK)
    if (push) mem[wr_ptr] <= {CMD, BA, ADDR, WR_DATA, DM};
  always_ff @(posedge CPU_CLK or negedge RESET_N)
    if (!RESET_N) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      Q_LEVEL <= '0;
      Q_VALID <= 1'b0;
      CMD_RDY <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      Q_LEVEL <= level_n;
      Q_VALID <= level_n != '0;
      CMD_RDY <= level_n < LW'(DEPTH);
    end
`ifdef DDR3_CMDQ_STATS_EN
  always_ff @(posedge CPU_CLK or negedge RESET_N)
    if (!RESET_N) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else if (push) begin
      if (CMD) RD_CNT <= RD_CNT + 16'd1;
      else WR_CNT <= WR_CNT + 16'd1;
    end
`endif
endmodule
